score_cell_calc: RTL and testbench

SCORE_CELL_CALC -- requirements
Module: score_cell_calc

---
 rtl/score_cell_calc.sv | 175 +++++++++++++++++
 tb/tb_score_cell_calc.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_cell_calc.sv
// Single-cell score calculator for a Needleman-Wunsch style matrix fill.
// Reads three neighbour scores, picks the best step, writes max/dir back.
module score_cell_calc #(
  parameter int N        = 5,
  parameter int MATCH    = 1,
  parameter int MISMATCH = -1,
  parameter int GAP      = -2,
  localparam int BitAddr = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          char_a,
  input  logic [1:0]          char_b,
  input  logic signed [8:0]   diag,
  input  logic signed [8:0]   left,
  input  logic signed [8:0]   up,
  input  logic                ready,
  output logic                en_read,
  output logic [1:0]          count_3,
  output logic [BitAddr:0]    i,
  output logic [BitAddr:0]    j,
  output logic                en_ins,
  output logic signed [8:0]   max,
  output logic [1:0]          dir,
  output logic                busy,
  output logic                done
);

  localparam int W = BitAddr + 1;
  localparam logic [BitAddr:0] LAST = W'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CALC,
    WR,
    DONE
  } state_t;

  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [BitAddr:0] i_q, i_d, j_q, j_d;
  logic signed [8:0] max_q, max_d;
  logic [1:0] dir_q, dir_d;
  logic signed [8:0] dg_q, dg_d, lf_q, lf_d, up_q, up_d;

  logic signed [9:0] d10, l10, u10;
  logic signed [8:0] d_s, l_s, u_s;

  function automatic logic signed [8:0] sat(
    input logic signed [9:0] v
  );
    if (v > 10'sd255) return 9'sh0ff;
    else if (v < -10'sd256) return 9'sh100;
    else return v[8:0];
  endfunction

  // Candidate scores for the three possible steps, saturated to 9 bits.
  always_comb begin
    d10 = {dg_q[8], dg_q}
        + ((char_a == char_b) ? 10'(MATCH) : 10'(MISMATCH));
    l10 = {lf_q[8], lf_q} + 10'(GAP);
    u10 = {up_q[8], up_q} + 10'(GAP);
    d_s = sat(d10);
    l_s = sat(l10);
    u_s = sat(u10);
  end

  // Next-state, datapath and control for the per-cell sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    i_d     = i_q;
    j_d     = j_q;
    max_d   = max_q;
    dir_d   = dir_q;
    dg_d    = dg_q;
    lf_d    = lf_q;
    up_d    = up_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          cnt_d   = 2'b00;
          state_d = RD;
        end
      end
      RD: begin
        if (ready) begin
          unique case (cnt_q)
            2'b00:   dg_d = diag;
            2'b01:   lf_d = left;
            default: up_d = up;
          endcase
          if (cnt_q == 2'b10) begin
            cnt_d   = 2'b00;
            state_d = CALC;
          end else begin
            cnt_d = cnt_q + 2'b01;
          end
        end
      end
      CALC: begin
        if (d_s >= u_s && d_s >= l_s) begin
          max_d = d_s;
          dir_d = 2'b00;
        end else if (u_s >= l_s) begin
          max_d = u_s;
          dir_d = 2'b10;
        end else begin
          max_d = l_s;
          dir_d = 2'b01;
        end
        state_d = WR;
      end
      WR: begin
        cnt_d = 2'b00;
        if (i_q == LAST && j_q == LAST) begin
          i_d     = '0;
          j_d     = '0;
          state_d = DONE;
        end else begin
          if (j_q == LAST) begin
            j_d = '0;
            i_d = i_q + 1'b1;
          end else begin
            j_d = j_q + 1'b1;
          end
          state_d = RD;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'b00;
      i_q     <= '0;
      j_q     <= '0;
      max_q   <= '0;
      dir_q   <= 2'b00;
      dg_q    <= '0;
      lf_q    <= '0;
      up_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      j_q     <= j_d;
      max_q   <= max_d;
      dir_q   <= dir_d;
      dg_q    <= dg_d;
      lf_q    <= lf_d;
      up_q    <= up_d;
    end
  end

  assign en_read = (state_q == RD);
  assign en_ins  = (state_q == WR);
  assign busy    = (state_q == RD) || (state_q == CALC)
                || (state_q == WR);
  assign done    = (state_q == DONE);
  assign count_3 = cnt_q;
  assign i       = i_q;
  assign j       = j_q;
  assign max     = max_q;
  assign dir     = dir_q;

endmodule

// File: tb/tb_score_cell_calc.sv
// Bench for score_cell_calc: table-driven score manager,
// behavioural cell model and directed scenario checks.
module tb_score_cell_calc;

  localparam int N = 5;
  localparam int NC = N * N;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [1:0] char_a, char_b;
  logic signed [8:0] diag, left, up;
  logic ready = 1'b1;
  logic en_read, en_ins, busy, done;
  logic [1:0] count_3, dir;
  logic [$clog2(N):0] i, j;
  logic signed [8:0] max;

  score_cell_calc #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .char_a(char_a), .char_b(char_b),
    .diag(diag), .left(left), .up(up),
    .ready(ready), .en_read(en_read),
    .count_3(count_3), .i(i), .j(j),
    .en_ins(en_ins), .max(max), .dir(dir),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int td[NC], tl[NC], tu[NC];
  logic [1:0] ta[NC], tb[NC];
  int lit_max[5] = '{1, -2, -1, 255, -256};
  int lit_dir[5] = '{0, 0, 2, 0, 0};

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_idx = 0;
  int ins_cnt = 0;
  int done_cnt = 0;
  int last_ins = -1;
  bit spacing_chk = 0;

  // Score manager: neighbour scores and characters for the cell at (i,j).
  always_comb begin
    int k;
    k = int'(i) * N + int'(j);
    if (k >= NC) k = 0;
    diag   = 9'(td[k]);
    left   = 9'(tl[k]);
    up     = 9'(tu[k]);
    char_a = ta[k];
    char_b = tb[k];
  end

  function automatic int clamp(input int v);
    if (v > 255) return 255;
    if (v < -256) return -256;
    return v;
  endfunction

  task automatic model(input int k, output int m, output int dr);
    int d, l, u;
    d = clamp(td[k] + ((ta[k] == tb[k]) ? 1 : -1));
    l = clamp(tl[k] - 2);
    u = clamp(tu[k] - 2);
    if (d >= u && d >= l) begin m = d; dr = 0; end
    else if (u >= l) begin m = u; dr = 2; end
    else begin m = l; dr = 1; end
  endtask

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // One cycle: sample on the falling edge and check against the model.
  task automatic tick();
    int m, dr;
    @(negedge clk);
    cyc++;
    if (en_read && en_ins) chk("rd_ins_overlap", 1, 0);
    if (en_ins) begin
      if (exp_idx >= NC) begin
        chk("extra_en_ins", exp_idx, NC - 1);
      end else begin
        model(exp_idx, m, dr);
        chk("cell_i", int'(i), exp_idx / N);
        chk("cell_j", int'(j), exp_idx % N);
        chk("cell_max", int'(max), m);
        chk("cell_dir", int'(dir), dr);
        if (exp_idx < 5) begin
          chk("lit_max", int'(max), lit_max[exp_idx]);
          chk("lit_dir", int'(dir), lit_dir[exp_idx]);
        end
        if (spacing_chk && last_ins >= 0)
          chk("ins_spacing", cyc - last_ins, 5);
      end
      last_ins = cyc;
      exp_idx++;
      ins_cnt++;
    end
    if (done) done_cnt++;
  endtask

  task automatic new_run();
    exp_idx = 0;
    ins_cnt = 0;
    done_cnt = 0;
    last_ins = -1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int budget, input bit poke);
    int n;
    n = 0;
    while (!done && n < budget) begin
      if (poke && n == 30) start = 1'b1;
      tick();
      start = 1'b0;
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
    tick();
    chk("busy_after_done", int'(busy), 0);
    chk("done_one_cycle", int'(done), 0);
  endtask

  task automatic check_reset_vals();
    chk("rst_en_read", int'(en_read), 0);
    chk("rst_en_ins", int'(en_ins), 0);
    chk("rst_count_3", int'(count_3), 0);
    chk("rst_i", int'(i), 0);
    chk("rst_j", int'(j), 0);
    chk("rst_max", int'(max), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
  endtask

  initial begin
    int n;
    for (int k = 0; k < NC; k++) begin
      td[k] = int'($urandom_range(0, 511)) - 256;
      tl[k] = int'($urandom_range(0, 511)) - 256;
      tu[k] = int'($urandom_range(0, 511)) - 256;
      ta[k] = 2'($urandom_range(0, 3));
      tb[k] = 2'($urandom_range(0, 3));
    end
    td[0] = 0;    tl[0] = -2;   tu[0] = -2;
    ta[0] = 2;    tb[0] = 2;
    td[1] = -1;   tl[1] = -5;   tu[1] = 0;
    ta[1] = 0;    tb[1] = 1;
    td[2] = -1;   tl[2] = -5;   tu[2] = 1;
    ta[2] = 0;    tb[2] = 1;
    td[3] = 255;  tl[3] = 0;    tu[3] = 0;
    ta[3] = 3;    tb[3] = 3;
    td[4] = -256; tl[4] = -256; tu[4] = -256;
    ta[4] = 1;    tb[4] = 2;

    rst = 1'b0;
    tick();
    tick();
    check_reset_vals();
    rst = 1'b1;
    tick();

    new_run();
    spacing_chk = 1;
    pulse_start();
    run_to_done(400, 1);
    spacing_chk = 0;
    chk("sweep_ins_count", ins_cnt, NC);
    chk("sweep_done_count", done_cnt, 1);

    new_run();
    pulse_start();
    n = 0;
    while (!(en_read && count_3 == 2'b01) && n < 20) begin
      tick();
      n++;
    end
    chk("stall_reached", int'(en_read && count_3 == 2'b01), 1);
    ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      tick();
      chk("stall_count_3", int'(count_3), 1);
      chk("stall_en_read", int'(en_read), 1);
      chk("stall_en_ins", int'(en_ins), 0);
    end
    ready = 1'b1;
    run_to_done(400, 0);
    chk("stall_ins_count", ins_cnt, NC);
    chk("stall_done_count", done_cnt, 1);

    new_run();
    pulse_start();
    n = 0;
    while (!(i == 2 && j == 3 && busy && !en_read && !en_ins)
           && n < 200) begin
      tick();
      n++;
    end
    chk("calc_23_reached", int'(i == 2 && j == 3 && busy), 1);
    rst = 1'b0;
    tick();
    check_reset_vals();
    chk("mid_rst_ins_count", ins_cnt, 2 * N + 3);
    rst = 1'b1;
    tick();
    chk("mid_rst_ins_after", ins_cnt, 2 * N + 3);
    new_run();
    pulse_start();
    run_to_done(400, 0);
    chk("restart_ins_count", ins_cnt, NC);
    chk("restart_done_count", done_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
